// File: rtl/issue_unit_pkg.sv
// ============================================================================
// Module : issue_unit_pkg
// Brief  : CDB source encoding, default latencies and the CDB slot record.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package issue_unit_pkg;

  typedef enum logic [1:0] {
    CDB_SRC_INT  = 2'd0,
    CDB_SRC_LDST = 2'd1,
    CDB_SRC_MULT = 2'd2,
    CDB_SRC_DIV  = 2'd3
  } cdb_src_e;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 8;
  localparam int SLOT_IDX_W   = 4;

  typedef struct packed {
    logic     valid;
    cdb_src_e src;
  } cdb_slot_t;

endpackage

`default_nettype wire

// File: rtl/issue_unit_if.sv
// ============================================================================
// Module : issue_unit_if
// Brief  : Queue-head ready / pop handshake plus CDB source select bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface issue_unit_if;

  logic       int_ready;
  logic       ld_st_ready;
  logic       mult_ready;
  logic       div_ready;
  logic       flush;
  logic       int_rd;
  logic       ld_st_rd;
  logic       mult_rd;
  logic       div_rd;
  logic       cdb_src_valid;
  logic [1:0] cdb_src_sel;
  logic       div_busy;

  // Queue / pipeline side
  modport master (
    output int_ready, ld_st_ready, mult_ready, div_ready, flush,
    input  int_rd, ld_st_rd, mult_rd, div_rd, cdb_src_valid, cdb_src_sel, div_busy
  );

  // Issue unit side
  modport slave (
    input  int_ready, ld_st_ready, mult_ready, div_ready, flush,
    output int_rd, ld_st_rd, mult_rd, div_rd, cdb_src_valid, cdb_src_sel, div_busy
  );

endinterface

`default_nettype wire

// File: rtl/issue_unit_cdb_reservation_sreg.sv
// ============================================================================
// Module : cdb_reservation_sreg
// Brief  : CDB booking shift register; slot 0 is the slot broadcasting now.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cdb_reservation_sreg
  import issue_unit_pkg::*;
#(
  parameter int DEPTH = DIV_LAT_DEF
) (
  input  wire logic                       i_clk,
  input  wire logic                       i_rst_n,
  input  wire logic [2:0]                 book_vld,
  input  wire logic [2:0][SLOT_IDX_W-1:0] book_idx,
  input  wire logic [2:0][1:0]            book_src,
  output cdb_slot_t                       cur,
  output logic [DEPTH:1]                  occ
);

  cdb_slot_t slot_q [0:DEPTH];
  cdb_slot_t slot_d [0:DEPTH];

  // A booking for k cycles ahead lands at index k-1 because the whole
  // register advances by one on the same edge.
  always_comb begin
    slot_d = slot_q;
    for (int k = 0; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    slot_d[DEPTH] = '0;
    for (int b = 0; b < 3; b++) begin
      if (book_vld[b]) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (book_idx[b] == SLOT_IDX_W'(k)) begin
            slot_d[k-1] = '{valid: 1'b1, src: cdb_src_e'(book_src[b])};
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k <= DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k <= DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign cur = slot_q[0];

  for (genvar k = 1; k <= DEPTH; k++) begin : g_occ
    assign occ[k] = slot_q[k].valid;
  end

endmodule

`default_nettype wire

// File: rtl/issue_unit.sv
// ============================================================================
// Module : issue_unit
// Brief  : Picks which execution-queue heads issue, keeping the CDB collision-free.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input wire logic     i_clk,
  input wire logic     i_rst_n,
  issue_unit_if.slave  bus
);

  cdb_slot_t                       cur;
  logic [DIV_LAT:1]                occ;
  logic [2:0]                      book_vld;
  logic [2:0][SLOT_IDX_W-1:0]      book_idx;
  logic [2:0][1:0]                 book_src;

  logic       lru_q, lru_d;
  logic [3:0] div_cnt_q, div_cnt_d;
  logic       int_rd, ld_st_rd, mult_rd, div_rd, div_busy;

  always_comb begin
    int_rd   = 1'b0;
    ld_st_rd = 1'b0;
    mult_rd  = 1'b0;
    div_rd   = 1'b0;
    div_busy = (div_cnt_q != 4'd0);
    if (!bus.flush) begin
      div_rd  = bus.div_ready & ~div_busy & ~occ[DIV_LAT];
      mult_rd = bus.mult_ready & ~occ[MULT_LAT];
      if (!occ[1]) begin
        if (bus.int_ready && bus.ld_st_ready) begin
          int_rd   = ~lru_q;
          ld_st_rd = lru_q;
        end else begin
          int_rd   = bus.int_ready;
          ld_st_rd = bus.ld_st_ready;
        end
      end
    end
  end

  always_comb begin
    lru_d = lru_q;
    if (int_rd) begin
      lru_d = 1'b1;
    end else if (ld_st_rd) begin
      lru_d = 1'b0;
    end
    div_cnt_d = div_cnt_q;
    if (div_rd) begin
      div_cnt_d = 4'(DIV_LAT - 1);
    end else if (div_cnt_q != 4'd0) begin
      div_cnt_d = div_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lru_q     <= 1'b0;
      div_cnt_q <= 4'd0;
    end else begin
      lru_q     <= lru_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    book_vld    = {div_rd, mult_rd, int_rd | ld_st_rd};
    book_idx[0] = SLOT_IDX_W'(1);
    book_idx[1] = SLOT_IDX_W'(MULT_LAT);
    book_idx[2] = SLOT_IDX_W'(DIV_LAT);
    book_src[0] = int_rd ? CDB_SRC_INT : CDB_SRC_LDST;
    book_src[1] = CDB_SRC_MULT;
    book_src[2] = CDB_SRC_DIV;
  end

  cdb_reservation_sreg #(
    .DEPTH (DIV_LAT)
  ) u_sreg (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .book_vld (book_vld),
    .book_idx (book_idx),
    .book_src (book_src),
    .cur      (cur),
    .occ      (occ)
  );

  assign bus.int_rd        = int_rd;
  assign bus.ld_st_rd      = ld_st_rd;
  assign bus.mult_rd       = mult_rd;
  assign bus.div_rd        = div_rd;
  assign bus.div_busy      = div_busy;
  assign bus.cdb_src_valid = cur.valid;
  assign bus.cdb_src_sel   = cur.src;

endmodule

`default_nettype wire

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Read side of the four dispatch execution queues: integer, load/store, multiply and divide.
- Each cycle it decides which queue heads leave for their execution units and pulses the matching read-enable (int_rd, ld_st_rd, mult_rd, div_rd).
- It keeps a CDB reservation shift register, so at most one result is broadcast per cycle and no two units ever collide on the CDB.
- It also drives the CDB source select, which steers the CDB tag/data mux.

Parameters:
- MULT_LAT, 4, issue-to-CDB cycles for the pipelined multiplier; legal range 2..DIV_LAT-1.
- DIV_LAT, 8, issue-to-CDB cycles for the non-pipelined divider; legal range MULT_LAT+1..15.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- int_ready  in  1  int queue head valid and both operand tags resolved
- ld_st_ready  in  1  ld/st queue head valid and both operand tags resolved
- mult_ready  in  1  mult queue head valid and both operand tags resolved
- div_ready  in  1  div queue head valid and both operand tags resolved
- flush  in  1  cdb_branch_taken; suppresses all grants this cycle
- int_rd  out  1  pop int queue, issue to ALU
- ld_st_rd  out  1  pop ld/st queue, issue to AGU/memory
- mult_rd  out  1  pop mult queue, issue to multiplier
- div_rd  out  1  pop div queue, issue to divider
- cdb_src_valid  out  1  a unit owns the CDB this cycle
- cdb_src_sel  out  2  owning unit: 0 int, 1 ld_st, 2 mult, 3 div
- div_busy  out  1  divider occupied

Behaviour:
- Latencies: int and ld_st results appear on the CDB 1 cycle after issue; mult after MULT_LAT cycles; div after DIV_LAT cycles.
- State:
  - res[1..DIV_LAT] valid bits, each with a 2-bit src field; res[k] set means the CDB slot k cycles ahead is booked.
  - Registered cur_valid / cur_src for the present slot.
  - 1-bit lru (0: int preferred, 1: ld_st preferred).
  - 4-bit div_cnt.
- Grant rules (combinational from state and inputs; all forced 0 when flush=1):
  - div_rd = div_ready & ~div_busy & ~res[DIV_LAT].
  - mult_rd = mult_ready & ~res[MULT_LAT].
  - Slot-1 contenders are int_ready and ld_st_ready, and only when ~res[1].
    - If both contend, the lru-preferred one wins.
    - If one contends, it wins.
- Clock edge:
  - cur_valid/cur_src <= res[1].
  - res[k] <= res[k+1] for k < DIV_LAT; res[DIV_LAT] <= 0.
  - Then OR in the new bookings: slot 1 for an int/ld_st grant, slot MULT_LAT for mult, slot DIV_LAT for div, each with its src.
  - Grants never target the same slot, because MULT_LAT ≠ DIV_LAT and both exceed 1.
- lru: after an int grant lru<=1; after a ld_st grant lru<=0; otherwise unchanged. It flips only on an actual grant.
- Divider:
  - div_rd loads div_cnt <= DIV_LAT-1.
  - Decrement while nonzero.
  - div_busy = (div_cnt != 0).
  - A back-to-back divide may therefore issue exactly DIV_LAT cycles after the previous one, in the same cycle its result is on the CDB.
- Outputs: cdb_src_valid = cur_valid, cdb_src_sel = cur_src.
- flush:
  - Blocks new grants only.
  - Already-booked slots still broadcast; in-flight results keep their unique tags.
  - Queue contents are flushed by the queues themselves.
- Reset (async, while i_rst_n=0): res, cur_valid, cur_src, lru, div_cnt all 0. Hence every rd output is 0, cdb_src_valid=0, cdb_src_sel=0, div_busy=0. Reset asserted mid-operation discards all bookings.
- Ready inputs are sampled the same cycle. The queues pop on the rising edge on which rd=1.

Decomposition:
- Shared package (existing utils package):
  - CDB source enum: CDB_SRC_INT=0, CDB_SRC_LDST=1, CDB_SRC_MULT=2, CDB_SRC_DIV=3.
  - Default latency constants MULT_LAT_DEF=4, DIV_LAT_DEF=8.
  - Struct cdb_slot {valid, src}.
- Sub-module cdb_reservation_sreg:
  - Parameterised depth.
  - Three booking ports (index, src).
  - Outputs the current slot and the occupancy vector.
- Arbitration and divider counter stay in issue_unit.

Test Plan:
- Reset then idle, all ready=0: all rd=0, cdb_src_valid=0 every cycle.
- int_ready=ld_st_ready=1 held for 4 cycles from lru=0: grants alternate int, ld_st, int, ld_st; cdb_src_sel follows 0,1,0,1 one cycle later, with cdb_src_valid=1 continuously.
- mult_rd at cycle t, int_ready=1 throughout:
  - int issues every cycle except t+MULT_LAT-1 (res[1] booked), when it is stalled.
  - CDB shows src=2 at t+4.
- Divides:
  - div_ready=1 continuously: div_rd pulses at t and t+8 only, div_busy high for cycles t+1..t+7, CDB src=3 at t+8 and t+16.
  - A mult whose slot falls on t+8 is refused.
- flush=1 for one cycle with all ready=1: all rd=0 that cycle; a previously booked mult still appears on the CDB at its slot.
- Reset asserted with 3 slots booked: cdb_src_valid=0 immediately, no later broadcast; first grant is legal on the cycle after release.
